// File: rtl/wb_load_sequencer.sv
// Register-file write-port sequencer: passes non-load writes straight through and
// stalls the core while RAM or IO load data is collected, then writes it back.
module wb_load_sequencer #(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        is_io,
    input  logic        jal,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        io_rd_req,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        IO_WAIT,
        WB
    } state_t;

    state_t         state;
    logic [31:0]    buffer;
    logic [4:0]     wb_rd;
    logic [TW-1:0]  timer;
    logic           load_issue;

    assign load_issue = instr_valid & mem_to_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            buffer      <= '0;
            wb_rd       <= '0;
            timer       <= '0;
            io_rd_req   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_issue) begin
                        wb_rd <= rd;
                        timer <= '0;
                        if (is_io) begin
                            state     <= IO_WAIT;
                            io_rd_req <= 1'b1;
                        end else begin
                            state <= RAM_WAIT;
                        end
                    end
                end
                RAM_WAIT: begin
                    buffer <= ram_rdata;
                    state  <= WB;
                end
                IO_WAIT: begin
                    // An ack arriving in the final timer cycle still delivers real data.
                    if (io_ack) begin
                        buffer    <= io_rdata;
                        io_rd_req <= 1'b0;
                        state     <= WB;
                    end else if (timer == TIMER_LAST) begin
                        buffer      <= ERR_DATA;
                        timeout_err <= 1'b1;
                        io_rd_req   <= 1'b0;
                        state       <= WB;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Non-load writes must land in the issuing cycle, so the write port is decoded combinationally.
    always_comb begin
        stall    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = wb_rd;
        rf_wdata = buffer;
        if (!rst_n) begin
            rf_waddr = '0;
            rf_wdata = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_issue) begin
                        stall = 1'b1;
                    end else begin
                        rf_we    = instr_valid & reg_write & (rd != 5'd0);
                        rf_waddr = rd;
                        rf_wdata = jal ? pc_plus4 : alu_result;
                    end
                end
                RAM_WAIT, IO_WAIT: begin
                    stall = 1'b1;
                end
                WB: begin
                    rf_we = (wb_rd != 5'd0);
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_load_sequencer.sv
// Scoreboard bench for wb_load_sequencer: the driver pushes expected regfile writes,
// a monitor pops and compares them whenever rf_we is seen.
module tb_wb_load_sequencer;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, reg_write, mem_to_reg, is_io, jal;
    logic [4:0]  rd;
    logic [31:0] alu_result, pc_plus4, ram_rdata, io_rdata;
    logic        io_ack;
    logic        io_rd_req, stall, rf_we, timeout_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  exp_terr = 1'b0;

    wb_load_sequencer #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .is_io(is_io), .jal(jal), .rd(rd),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .ram_rdata(ram_rdata),
        .io_rdata(io_rdata), .io_ack(io_ack), .io_rd_req(io_rd_req), .stall(stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
                check_output("wr_data", rf_wdata, e.data);
            end
        end
    end

    // kind: 0 non-load, 1 RAM load, 2 IO load acked in wait cycle k, 3 IO load that times out.
    // val is alu_result (or pc_plus4 when jal) for kind 0, and the load data otherwise.
    task automatic apply_stimulus(input int kind, input bit valid, input bit rw, input bit jl,
                                  input logic [4:0] r, input logic [31:0] val, input int k);
        int          ncyc;
        bit          wr;
        logic [31:0] d;
        if (kind != 0) valid = 1'b1;
        instr_valid = valid;
        reg_write   = rw;
        mem_to_reg  = (kind != 0);
        is_io       = (kind >= 2);
        jal         = jl;
        rd          = r;
        alu_result  = $urandom;
        pc_plus4    = $urandom;
        case (kind)
            0: begin
                if (jl) pc_plus4 = val; else alu_result = val;
                d = val;
                wr = valid && rw && (r != 5'd0);
                ncyc = 1;
            end
            1: begin d = val; wr = (r != 5'd0); ncyc = 3; end
            2: begin d = val; wr = (r != 5'd0); ncyc = k + 2; end
            default: begin d = ERR; wr = (r != 5'd0); ncyc = TO + 2; end
        endcase
        if (wr) exp_q.push_back('{addr: r, data: d});
        for (int c = 0; c < ncyc; c++) begin
            bit exp_stall, exp_req, exp_we;
            ram_rdata = (kind == 1 && c == 1) ? val : $urandom;
            io_rdata  = (kind == 2 && c == k) ? val : $urandom;
            if (kind == 2 && c >= 1 && c <= k)       io_ack = (c == k);
            else if (kind == 3 && c >= 1 && c <= TO) io_ack = 1'b0;
            else                                     io_ack = 1'($urandom);
            if (kind != 0 && c == ncyc - 1) begin
                instr_valid = 1'($urandom);
                reg_write   = 1'($urandom);
                mem_to_reg  = 1'($urandom);
                is_io       = 1'($urandom);
                rd          = 5'($urandom);
            end
            @(negedge clk);
            exp_stall = (kind != 0) && (c < ncyc - 1);
            exp_req   = (kind == 2 && c >= 1 && c <= k) || (kind == 3 && c >= 1 && c <= TO);
            exp_we    = wr && (c == ncyc - 1);
            if (kind == 3 && c == ncyc - 1) exp_terr = 1'b1;
            check_output("stall", {31'd0, stall}, {31'd0, exp_stall});
            check_output("io_rd_req", {31'd0, io_rd_req}, {31'd0, exp_req});
            check_output("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
            check_output("timeout_err", {31'd0, timeout_err}, {31'd0, exp_terr});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_mid_io();
        apply_quiet_load();
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        check_output("rst_we", {31'd0, rf_we}, 32'd0);
        check_output("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check_output("rst_wdata", rf_wdata, 32'd0);
        @(posedge clk);
        #1;
        exp_terr    = 1'b0;
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        mem_to_reg  = 1'b0;
        io_ack      = 1'b1;
        @(negedge clk);
        check_output("post_rst_req", {31'd0, io_rd_req}, 32'd0);
        check_output("post_rst_stall", {31'd0, stall}, 32'd0);
        check_output("post_rst_we", {31'd0, rf_we}, 32'd0);
        check_output("post_rst_terr", {31'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        io_ack = 1'b0;
        @(negedge clk);
        check_output("late_ack_req", {31'd0, io_rd_req}, 32'd0);
        check_output("late_ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Issue an IO load and sit two cycles in the wait state without ack.
    task automatic apply_quiet_load();
        instr_valid = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; is_io = 1'b1;
        jal = 1'b0; rd = 5'd11; io_ack = 1'b0;
        @(negedge clk);
        check_output("abort_issue_stall", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_output("abort_wait_req", {31'd0, io_rd_req}, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; is_io = 1'b0;
        jal = 1'b0; rd = 5'd5; alu_result = 32'h1234; pc_plus4 = 32'h4; ram_rdata = '0;
        io_rdata = '0; io_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_stall", {31'd0, stall}, 32'd0);
        check_output("reset_we", {31'd0, rf_we}, 32'd0);
        check_output("reset_waddr", {27'd0, rf_waddr}, 32'd0);
        check_output("reset_wdata", rf_wdata, 32'd0);
        check_output("reset_req", {31'd0, io_rd_req}, 32'd0);
        check_output("reset_terr", {31'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_stimulus(0, 1, 1, 0, 5'd5, 32'h12, 0);
        apply_stimulus(0, 1, 1, 1, 5'd5, 32'h40, 0);
        apply_stimulus(0, 1, 1, 0, 5'd0, 32'h99, 0);
        apply_stimulus(0, 0, 1, 0, 5'd6, 32'h77, 0);
        apply_stimulus(1, 1, 1, 0, 5'd7, 32'hCAFE0001, 0);
        apply_stimulus(2, 1, 1, 0, 5'd3, 32'h55, 4);
        apply_stimulus(1, 1, 1, 0, 5'd0, 32'h1111, 0);
        apply_stimulus(2, 1, 1, 0, 5'd0, 32'h2222, 2);
        apply_stimulus(2, 1, 1, 0, 5'd12, 32'hA5A5A5A5, TO);
        apply_stimulus(3, 1, 1, 0, 5'd9, 32'h0, 0);

        for (int i = 0; i < 80; i++) begin
            int          sel;
            logic [4:0]  r;
            sel = $urandom_range(0, 9);
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if (sel <= 2)
                apply_stimulus(0, ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), r, $urandom, 0);
            else if (sel <= 4)
                apply_stimulus(1, 1, 1, 0, r, $urandom, 0);
            else if (sel <= 7)
                apply_stimulus(2, 1, 1, 0, r, $urandom, $urandom_range(1, 6));
            else if (sel == 8)
                apply_stimulus(2, 1, 1, 0, r, $urandom, TO);
            else
                apply_stimulus(3, 1, 1, 0, r, 32'h0, 0);
        end

        reset_mid_io();
        apply_stimulus(0, 1, 1, 0, 5'd20, 32'h0BADF00D, 0);
        apply_stimulus(1, 1, 1, 0, 5'd21, 32'h13579BDF, 0);

        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
